// File: rtl/sqrt_round_if.sv
// Handshake bundle for the square-root rounding/packing stage.
//
// Upstream side : in_root/in_sticky/in_exp/in_sign/in_cls/rnd_mode, qualified by
//                 the one-cycle strobe in_done (never refused).
// Downstream side: out_result/out_inexact/out_invalid at the FIFO head, with
//                 out_valid/out_ready handshake; ovf_err reports a dropped strobe.
//
// master: the environment (drives stimulus, consumes results).
// slave : the sqrt_round block.
interface sqrt_round_if #(
   parameter int WIDTH = 26,
   parameter int EXP_W = 8
);
   logic [WIDTH-1:0] in_root;
   logic             in_sticky;
   logic             in_done;
   logic [EXP_W-1:0] in_exp;
   logic             in_sign;
   logic [2:0]       in_cls;
   logic [2:0]       rnd_mode;
   logic [31:0]      out_result;
   logic             out_inexact;
   logic             out_invalid;
   logic             out_valid;
   logic             out_ready;
   logic             ovf_err;

   modport master (
      output in_root, in_sticky, in_done, in_exp, in_sign, in_cls, rnd_mode, out_ready,
      input  out_result, out_inexact, out_invalid, out_valid, ovf_err
   );

   modport slave (
      input  in_root, in_sticky, in_done, in_exp, in_sign, in_cls, rnd_mode, out_ready,
      output out_result, out_inexact, out_invalid, out_valid, ovf_err
   );
endinterface

// File: rtl/sqrt_round.sv
// Final stage of a single-precision square root: rounds the normalized root,
// packs the IEEE-754 result (or the special-case encoding for the operand class)
// and queues it in a 2-entry FIFO so the upstream stage never stalls.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset; empties the FIFO immediately
//   bus  - sqrt_round_if.slave: input strobe bundle and output FIFO head
//          with valid/ready handshake plus the sticky ovf_err flag
module sqrt_round #(
   parameter int WIDTH  = 26,
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic        clk,
   input  logic        rst,
   sqrt_round_if.slave bus
);

   typedef enum logic [2:0] {
      CLS_NORMAL = 3'd0,
      CLS_ZERO   = 3'd1,
      CLS_PINF   = 3'd2,
      CLS_QNAN   = 3'd3,
      CLS_SNAN   = 3'd4,
      CLS_NEG    = 3'd5
   } cls_e;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rnd_e;

   typedef struct packed {
      logic [31:0] result;
      logic        inexact;
      logic        invalid;
   } entry_t;

   localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

   // ---------------------------------------------------------------------
   // Rounding and packing (combinational on the strobe inputs)
   // ---------------------------------------------------------------------
   logic              guard_bit, round_bit, lsb_bit, inexact, round_up, carry;
   logic [FRAC_W+1:0] mant_sum;
   logic [EXP_W:0]    exp_inc;
   entry_t            entry;

   assign guard_bit = bus.in_root[1];
   assign round_bit = bus.in_root[0];
   assign lsb_bit   = bus.in_root[2];
   assign inexact   = guard_bit | round_bit | bus.in_sticky;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the case statements can leave it unassigned (no latch).
      round_up = 1'b0;
      case (rnd_e'(bus.rnd_mode))
         RM_RTZ, RM_RDN: round_up = 1'b0;   // result is never negative
         RM_RUP:         round_up = inexact;
         RM_RMM:         round_up = guard_bit;
         default:        round_up = guard_bit & (round_bit | bus.in_sticky | lsb_bit);
      endcase
   end

   // Hidden bit included: the top two sum bits read 01 normally and 10 only when
   // the increment rippled out past the hidden 1.
   assign mant_sum = {1'b0, bus.in_root[WIDTH-1:2]} + {{(FRAC_W+1){1'b0}}, round_up};
   assign carry    = (mant_sum[FRAC_W+1:FRAC_W] == 2'b10);
   assign exp_inc  = {1'b0, bus.in_exp} + {{EXP_W{1'b0}}, carry};

   always_comb begin
      entry = '0;
      case (cls_e'(bus.in_cls))
         CLS_NORMAL: begin
            entry.inexact = inexact;
            if (carry && (exp_inc >= EXP_MAX)) begin
               entry.result = 32'h7F80_0000;
            end else begin
               // On carry the low fraction bits of the sum are already zero.
               entry.result = {1'b0, exp_inc[EXP_W-1:0], mant_sum[FRAC_W-1:0]};
            end
         end
         CLS_ZERO: entry.result = {bus.in_sign, 31'b0};
         CLS_PINF: entry.result = 32'h7F80_0000;
         CLS_SNAN, CLS_NEG: begin
            entry.result  = 32'h7FC0_0000;
            entry.invalid = 1'b1;
         end
         default:  entry.result = 32'h7FC0_0000;  // qNaN, and unused codes 6-7
      endcase
   end

   // ---------------------------------------------------------------------
   // 2-entry FIFO
   // ---------------------------------------------------------------------
   entry_t     fifo_q [2];
   logic       wr_ptr, rd_ptr;
   logic [1:0] count;
   logic       ovf_err_q;
   logic       full, pop, push_ok, push_drop;

   assign full      = (count == 2'd2);
   assign pop       = (count != 2'd0) & bus.out_ready;
   // A pop frees the head slot on the same edge, so a full FIFO can still accept.
   assign push_ok   = bus.in_done & (~full | pop);
   assign push_drop = bus.in_done & full & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         ovf_err_q <= 1'b0;
         // NOTE: the storage is reset too, because the head is visible on the
         // outputs and must read as zero while in reset.
         for (int i = 0; i < 2; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         // NOTE: all state here uses non-blocking assignments so every register
         // sees the pre-edge values regardless of statement order.
         if (push_ok) begin
            fifo_q[wr_ptr] <= entry;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (push_drop) begin
            ovf_err_q <= 1'b1;
         end
      end
   end

   assign bus.out_result  = fifo_q[rd_ptr].result;
   assign bus.out_inexact = fifo_q[rd_ptr].inexact;
   assign bus.out_invalid = fifo_q[rd_ptr].invalid;
   assign bus.out_valid   = (count != 2'd0);
   assign bus.ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_sqrt_round.sv
// Directed bench for sqrt_round: expected entries are queued when a strobe is
// driven and compared against the FIFO head when it is consumed.
module tb_sqrt_round;

   typedef struct packed {
      logic [31:0] result;
      logic        inexact;
      logic        invalid;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;
   exp_t sb_q[$];

   sqrt_round_if #(.WIDTH(26), .EXP_W(8)) bus ();

   sqrt_round #(.WIDTH(26), .EXP_W(8), .FRAC_W(23)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Independent reference: rounds a 24-bit significand and renormalizes.
   function automatic exp_t model(input logic [25:0] root, input logic sticky,
                                  input logic [7:0] e8, input logic sign,
                                  input logic [2:0] cls, input logic [2:0] mode);
      exp_t        o;
      logic        g, r, l, up, carried;
      logic [24:0] m;
      int          e;
      o.result  = 32'h7FC0_0000;
      o.inexact = 1'b0;
      o.invalid = 1'b0;
      case (cls)
         3'd0: begin
            g = root[1];
            r = root[0];
            l = root[2];
            case (mode)
               3'd1, 3'd2: up = 1'b0;
               3'd3:       up = g | r | sticky;
               3'd4:       up = g;
               default:    up = g & (r | sticky | l);
            endcase
            m = {1'b0, root[25:2]} + {24'b0, up};
            e = int'(e8);
            carried = m[24];
            if (carried) begin
               e++;
               m = m >> 1;
            end
            o.inexact = g | r | sticky;
            if (carried && e >= 255) o.result = 32'h7F80_0000;
            else                     o.result = {1'b0, 8'(e), m[22:0]};
         end
         3'd1:       o.result = {sign, 31'b0};
         3'd2:       o.result = 32'h7F80_0000;
         3'd4, 3'd5: o.invalid = 1'b1;
         default:    o.result = 32'h7FC0_0000;
      endcase
      return o;
   endfunction

   task automatic load(input logic [25:0] root, input logic sticky, input logic [7:0] e8,
                       input logic sign, input logic [2:0] cls, input logic [2:0] mode);
      bus.in_root   = root;
      bus.in_sticky = sticky;
      bus.in_exp    = e8;
      bus.in_sign   = sign;
      bus.in_cls    = cls;
      bus.rnd_mode  = mode;
   endtask

   // Called at a negedge; returns at the following negedge with in_done low.
   task automatic strobe(input exp_t e, input bit keep);
      bus.in_done = 1'b1;
      if (keep) sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.in_done = 1'b0;
   endtask

   // Compares the current head (at a negedge) with the oldest expectation.
   task automatic check_head(input string tag);
      exp_t e;
      check({tag, "_valid"}, {63'b0, bus.out_valid}, 64'd1);
      n_cmp++;
      assert (sb_q.size() != 0) else begin
         n_mis++;
         $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_result"}, {32'b0, bus.out_result}, {32'b0, e.result});
         check({tag, "_flags"}, {62'b0, bus.out_inexact, bus.out_invalid},
               {62'b0, e.inexact, e.invalid});
      end
   endtask

   // One strobe into an empty FIFO with the consumer ready: head after 1 cycle,
   // then empty after the pop.
   task automatic single(input string tag, input logic [25:0] root, input logic sticky,
                         input logic [7:0] e8, input logic sign, input logic [2:0] cls,
                         input logic [2:0] mode, input exp_t want);
      load(root, sticky, e8, sign, cls, mode);
      bus.out_ready = 1'b1;
      strobe(want, 1'b1);
      check_head(tag);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_empty"}, {63'b0, bus.out_valid}, 64'd0);
   endtask

   task automatic single_m(input string tag, input logic [25:0] root, input logic sticky,
                           input logic [7:0] e8, input logic sign, input logic [2:0] cls,
                           input logic [2:0] mode);
      single(tag, root, sticky, e8, sign, cls, mode, model(root, sticky, e8, sign, cls, mode));
   endtask

   function automatic exp_t mk(input logic [31:0] res, input logic ix, input logic iv);
      exp_t o;
      o.result  = res;
      o.inexact = ix;
      o.invalid = iv;
      return o;
   endfunction

   initial begin
      exp_t ea, eb, ec;
      bus.in_done   = 1'b0;
      bus.out_ready = 1'b0;
      load(26'h0, 1'b0, 8'h0, 1'b0, 3'd0, 3'd0);

      // Reset state
      #2;
      check("rst_valid",   {63'b0, bus.out_valid},   64'd0);
      check("rst_result",  {32'b0, bus.out_result},  64'd0);
      check("rst_flags",   {62'b0, bus.out_inexact, bus.out_invalid}, 64'd0);
      check("rst_ovf",     {63'b0, bus.ovf_err},     64'd0);
      #6 rst = 1'b1;
      @(negedge clk);

      // Rounding vectors with hand-derived expectations
      single("exact",    26'h2000000, 1'b0, 8'h80, 1'b0, 3'd0, 3'd0, mk(32'h4000_0000, 1'b0, 1'b0));
      single("tie_rne",  26'h2000002, 1'b0, 8'h7F, 1'b0, 3'd0, 3'd0, mk(32'h3F80_0000, 1'b1, 1'b0));
      single("tie_rup",  26'h2000002, 1'b0, 8'h7F, 1'b0, 3'd0, 3'd3, mk(32'h3F80_0001, 1'b1, 1'b0));
      single("tie_rmm",  26'h2000002, 1'b0, 8'h7F, 1'b0, 3'd0, 3'd4, mk(32'h3F80_0001, 1'b1, 1'b0));
      single("gr_rne",   26'h2000003, 1'b0, 8'h7F, 1'b0, 3'd0, 3'd0, mk(32'h3F80_0001, 1'b1, 1'b0));
      single("gr_rdn",   26'h2000003, 1'b0, 8'h7F, 1'b0, 3'd0, 3'd2, mk(32'h3F80_0000, 1'b1, 1'b0));
      single("carry",    26'h3FFFFFF, 1'b1, 8'h7F, 1'b0, 3'd0, 3'd0, mk(32'h4000_0000, 1'b1, 1'b0));
      single("carry_rtz",26'h3FFFFFF, 1'b1, 8'h7F, 1'b0, 3'd0, 3'd1, mk(32'h3FFF_FFFF, 1'b1, 1'b0));
      single("ovf_inf",  26'h3FFFFFF, 1'b1, 8'hFE, 1'b0, 3'd0, 3'd0, mk(32'h7F80_0000, 1'b1, 1'b0));
      single("ovf_rtz",  26'h3FFFFFF, 1'b1, 8'hFE, 1'b0, 3'd0, 3'd1, mk(32'h7F7F_FFFF, 1'b1, 1'b0));

      // Special classes
      single("snan",     26'h2000003, 1'b1, 8'h7F, 1'b0, 3'd4, 3'd0, mk(32'h7FC0_0000, 1'b0, 1'b1));
      single("negzero",  26'h0,       1'b0, 8'h00, 1'b1, 3'd1, 3'd0, mk(32'h8000_0000, 1'b0, 1'b0));
      single("poszero",  26'h0,       1'b0, 8'h00, 1'b0, 3'd1, 3'd3, mk(32'h0000_0000, 1'b0, 1'b0));
      single("pinf",     26'h2000003, 1'b1, 8'h7F, 1'b1, 3'd2, 3'd0, mk(32'h7F80_0000, 1'b0, 1'b0));
      single("qnan",     26'h2000003, 1'b1, 8'h7F, 1'b0, 3'd3, 3'd0, mk(32'h7FC0_0000, 1'b0, 1'b0));
      single("neg",      26'h2000003, 1'b1, 8'h7F, 1'b1, 3'd5, 3'd0, mk(32'h7FC0_0000, 1'b0, 1'b1));
      single("cls7",     26'h2000003, 1'b1, 8'h7F, 1'b0, 3'd7, 3'd0, mk(32'h7FC0_0000, 1'b0, 1'b0));

      // Random normals against the reference model
      for (int i = 0; i < 8; i++) begin
         single_m("rand", {1'b1, 25'($urandom)}, 1'($urandom_range(0, 1)),
                  8'($urandom_range(1, 250)), 1'b0, 3'd0, 3'($urandom_range(0, 4)));
      end

      // Full FIFO with simultaneous push and pop: nothing dropped
      bus.out_ready = 1'b0;
      load(26'h2000004, 1'b0, 8'h10, 1'b0, 3'd0, 3'd0); strobe(model(26'h2000004, 1'b0, 8'h10, 1'b0, 3'd0, 3'd0), 1'b1);
      load(26'h2000008, 1'b0, 8'h11, 1'b0, 3'd0, 3'd0); strobe(model(26'h2000008, 1'b0, 8'h11, 1'b0, 3'd0, 3'd0), 1'b1);
      check_head("full_a");
      load(26'h200000C, 1'b0, 8'h12, 1'b0, 3'd0, 3'd0);
      bus.out_ready = 1'b1;
      strobe(model(26'h200000C, 1'b0, 8'h12, 1'b0, 3'd0, 3'd0), 1'b1);
      check_head("full_b");
      @(posedge clk); @(negedge clk);
      check_head("full_c");
      @(posedge clk); @(negedge clk);
      check("full_empty", {63'b0, bus.out_valid}, 64'd0);
      check("full_noovf", {63'b0, bus.ovf_err},   64'd0);

      // One entry with simultaneous push and pop: new entry is the next head
      bus.out_ready = 1'b0;
      load(26'h2000010, 1'b0, 8'h20, 1'b0, 3'd0, 3'd0); strobe(model(26'h2000010, 1'b0, 8'h20, 1'b0, 3'd0, 3'd0), 1'b1);
      check_head("one_a");
      load(26'h2000014, 1'b0, 8'h21, 1'b0, 3'd0, 3'd0);
      bus.out_ready = 1'b1;
      strobe(model(26'h2000014, 1'b0, 8'h21, 1'b0, 3'd0, 3'd0), 1'b1);
      check_head("one_b");
      @(posedge clk); @(negedge clk);
      check("one_empty", {63'b0, bus.out_valid}, 64'd0);

      // Back-pressure: A and B held, C dropped
      bus.out_ready = 1'b0;
      ea = mk(32'h3F80_0001, 1'b1, 1'b0);
      eb = mk(32'h4000_0000, 1'b0, 1'b0);
      ec = mk(32'h7FC0_0000, 1'b0, 1'b1);
      load(26'h2000002, 1'b0, 8'h7F, 1'b0, 3'd0, 3'd3); strobe(ea, 1'b1);
      load(26'h2000000, 1'b0, 8'h80, 1'b0, 3'd0, 3'd0); strobe(eb, 1'b1);
      load(26'h2000000, 1'b0, 8'h80, 1'b0, 3'd4, 3'd0); strobe(ec, 1'b0);
      check("bp_ovf", {63'b0, bus.ovf_err}, 64'd1);
      check_head("bp_a");
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check_head("bp_b");
      @(posedge clk); @(negedge clk);
      check("bp_empty",    {63'b0, bus.out_valid}, 64'd0);
      check("bp_ovf_held", {63'b0, bus.ovf_err},   64'd1);

      // Reset mid-queue takes effect without a clock edge
      bus.out_ready = 1'b0;
      load(26'h2000004, 1'b0, 8'h30, 1'b0, 3'd0, 3'd0); strobe(mk(32'h0, 1'b0, 1'b0), 1'b0);
      load(26'h2000008, 1'b0, 8'h31, 1'b0, 3'd0, 3'd0); strobe(mk(32'h0, 1'b0, 1'b0), 1'b0);
      check("mq_valid_before", {63'b0, bus.out_valid}, 64'd1);
      #1 rst = 1'b0;
      #1;
      check("mq_valid",  {63'b0, bus.out_valid},  64'd0);
      check("mq_ovf",    {63'b0, bus.ovf_err},    64'd0);
      check("mq_result", {32'b0, bus.out_result}, 64'd0);
      #1 rst = 1'b1;
      @(negedge clk);
      single("after_rst", 26'h2000000, 1'b0, 8'h80, 1'b0, 3'd0, 3'd0, mk(32'h4000_0000, 1'b0, 1'b0));

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/sqrt_round.md
SQRT_ROUND -- requirements
Module: sqrt_round

Interface
REQ-001 Parameter: WIDTH, 26, width of the fixed-point root input (hidden bit + 23 fraction + guard + round).
REQ-002 Parameter: EXP_W, 8, width of the biased exponent.
REQ-003 Parameter: FRAC_W, 23, width of the stored fraction; WIDTH SHALL equal FRAC_W+3.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-low.
REQ-006 Port: in_root  in  WIDTH  normalized root; bit WIDTH-1 is the hidden 1, then fraction, then guard (bit 1), then round (bit 0).
REQ-007 Port: in_sticky  in  1  nonzero-remainder flag from the root stage.
REQ-008 Port: in_done  in  1  one-cycle strobe; the inputs are valid this cycle.
REQ-009 Port: in_exp  in  EXP_W  biased result exponent, already halved and bias-corrected upstream.
REQ-010 Port: in_sign  in  1  operand sign (meaningful for zero class only).
REQ-011 Port: in_cls  in  3  0 normal, 1 zero, 2 +inf, 3 qNaN, 4 sNaN, 5 negative nonzero (incl. -inf).
REQ-012 Port: rnd_mode  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; sampled with in_done.
REQ-013 Port: out_result  out  32  IEEE-754 single result at the FIFO head.
REQ-014 Port: out_inexact, out_invalid  out  1 each  flags at the FIFO head.
REQ-015 Port: out_valid  out  1  FIFO head valid; out_ready  in  1  consumer accepts the head.
REQ-016 Port: ovf_err  out  1  sticky error: a strobe was dropped because the FIFO was full.

Function
REQ-017 Normal class: G=in_root[1], R=in_root[0], S=in_sticky, L=in_root[2]; inexact=G|R|S.
REQ-018 Round-up decision: RNE G&(R|S|L); RTZ never; RDN never; RUP inexact; RMM G.
REQ-019 A round-up adds 1 to in_root[WIDTH-2:2]; on carry-out, fraction=0 and exponent=in_exp+1.
REQ-020 An incremented exponent of 255 SHALL produce +inf (0x7F800000) with out_inexact=1.
REQ-021 Normal result = {1'b0, exponent, fraction}; sign is always 0.
REQ-022 Zero class: result {in_sign,31'b0}, flags 0; +inf class: 0x7F800000, flags 0.
REQ-023 qNaN class: 0x7FC00000, flags 0; sNaN or negative class: 0x7FC00000, out_invalid=1, out_inexact=0.
REQ-024 Class codes 6-7 SHALL be treated as qNaN.
REQ-025 Rounding is combinational on the input strobe; the rounded entry is written into a 2-entry FIFO on in_done.
REQ-026 Latency: in_done at cycle N with an empty FIFO gives out_valid=1 at cycle N+1.
REQ-027 out_valid = FIFO not empty; a pop occurs when out_valid & out_ready.
REQ-028 Outputs SHALL be driven from the head register, not from the combinational path.
REQ-029 FIFO order is strict first-in first-out; read and write pointers wrap modulo 2.
REQ-030 Simultaneous push and pop with a full FIFO: both occur, and occupancy stays 2.
REQ-031 Simultaneous push and pop with one entry: both occur, and the new entry becomes the head next cycle.
REQ-032 Push to a full FIFO without a pop: the entry is dropped, FIFO contents are unchanged, and ovf_err is set.
REQ-033 ovf_err remains set until reset.
REQ-034 The block SHALL never stall the upstream stage; in_done is never refused.

Reset
REQ-035 While rst=0: FIFO emptied, pointers 0, out_valid=0, out_result=0, out_inexact=0, out_invalid=0, ovf_err=0.
REQ-036 Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock.
REQ-037 The first in_done accepted is the one sampled on the first rising edge with rst=1.

Verification
REQ-038 Exact: in_root=26'h2000000, in_sticky=0, in_exp=8'h80, RNE, cls 0 -> out_result=0x40000000, inexact=0, valid after 1 cycle.
REQ-039 Tie-even: in_root=26'h2000002, in_sticky=0, in_exp=8'h7F, RNE -> 0x3F800000, inexact=1; same with RUP -> 0x3F800001.
REQ-040 Carry: in_root=26'h3FFFFFF, in_sticky=1, in_exp=8'h7F, RNE -> 0x40000000, inexact=1; with RTZ -> 0x3FFFFFFF.
REQ-041 Specials: cls 4 -> 0x7FC00000 with invalid=1; cls 1 with in_sign=1 -> 0x80000000; cls 2 -> 0x7F800000.
REQ-042 Back-pressure: out_ready=0, three consecutive strobes A, B, C -> A and B are held in order, C is dropped, ovf_err=1; raising out_ready gives A then B.
REQ-043 Reset mid-queue: two entries queued, rst pulsed low between edges -> out_valid=0 at once, ovf_err=0, and the next strobe appears 1 cycle later.
